// File: rtl/wb_arb_pkg.sv
// Shared CPU constants and types for the register-file write arbiter.
// Register width, address width and the PC index live here so every user agrees.
package wb_arb_pkg;

  localparam int CPU_WIDTH     = 32;
  localparam int CPU_ADDR_SIZE = 4;
  localparam int CPU_PC_IDX    = (2 ** CPU_ADDR_SIZE) - 1;
  localparam int CPU_LD_DEPTH  = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_SKID = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_MEM  = 2'd3
  } commit_src_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of outstanding load destinations; per-entry valid bits and
// addresses are exposed so the arbiter can build its pending-load bitmap.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [AW-1:0]             push_wa,
  input  logic                      pop,
  output logic [AW-1:0]             head_wa,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0]          entry_valid,
  output logic [DEPTH-1:0][AW-1:0]  entry_wa
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][AW-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;

  // Pop clears before push sets, so a push into the slot freed this cycle wins.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q]   = push_wa;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign head_wa     = mem_q[rd_ptr_q];
  assign full        = &valid_q;
  assign empty       = ~|valid_q;
  assign entry_valid = valid_q;
  assign entry_wa    = mem_q;

endmodule

// File: rtl/wb_arb.sv
// Register-file write-port arbiter: link strobe, one-entry skid for displaced
// load data, ALU results and in-order load returns share a single write port.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int WIDTH     = CPU_WIDTH,
  parameter int ADDR_SIZE = CPU_ADDR_SIZE,
  parameter int DEPTH     = CPU_LD_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [ADDR_SIZE-1:0]      alu_wa,
  input  logic [WIDTH-1:0]          alu_d,
  output logic                      alu_ready,
  input  logic                      ld_issue,
  input  logic [ADDR_SIZE-1:0]      ld_wa,
  output logic                      ld_full,
  input  logic                      mem_valid,
  input  logic [WIDTH-1:0]          mem_d,
  output logic                      mem_ready,
  input  logic                      link_in,
  output logic                      wen,
  output logic [ADDR_SIZE-1:0]      wa,
  output logic [WIDTH-1:0]          din,
  output logic                      link,
  output logic [2**ADDR_SIZE-1:0]   busy,
  output logic                      err
);

  localparam int NREG = 2 ** ADDR_SIZE;

  logic                           skid_full_q, skid_full_d;
  logic [ADDR_SIZE-1:0]           skid_wa_q, skid_wa_d;
  logic [WIDTH-1:0]               skid_data_q, skid_data_d;
  logic                           err_q, err_d;

  logic                           fifo_push, fifo_pop;
  logic                           fifo_full, fifo_empty;
  logic [ADDR_SIZE-1:0]           head_wa;
  logic [DEPTH-1:0]               entry_valid;
  logic [DEPTH-1:0][ADDR_SIZE-1:0] entry_wa;

  logic                           alu_acc, mem_acc;
  logic [NREG-1:0]                busy_v;
  commit_src_e                    src;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (ADDR_SIZE)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .push_wa     (ld_wa),
    .pop         (fifo_pop),
    .head_wa     (head_wa),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_wa    (entry_wa)
  );

  always_comb begin
    busy_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) busy_v[entry_wa[i]] = 1'b1;
    end
    if (skid_full_q) busy_v[skid_wa_q] = 1'b1;
  end

  assign busy      = busy_v;
  assign link      = link_in;
  assign alu_ready = !link_in && !skid_full_q && !busy_v[alu_wa];
  assign mem_ready = !skid_full_q && !fifo_empty;
  assign alu_acc   = alu_valid && alu_ready;
  assign mem_acc   = mem_valid && mem_ready;
  assign fifo_pop  = mem_acc;
  // A full queue still accepts an issue when the head leaves in the same cycle.
  assign fifo_push = ld_issue && (!fifo_full || fifo_pop);
  assign ld_full   = fifo_full;
  assign err       = err_q;

  always_comb begin
    src = SRC_NONE;
    if (!link_in) begin
      if (skid_full_q)  src = SRC_SKID;
      else if (alu_acc) src = SRC_ALU;
      else if (mem_acc) src = SRC_MEM;
    end
  end

  always_comb begin
    wen = 1'b0;
    wa  = '0;
    din = '0;
    case (src)
      SRC_SKID: begin wen = 1'b1; wa = skid_wa_q; din = skid_data_q; end
      SRC_ALU:  begin wen = 1'b1; wa = alu_wa;    din = alu_d;       end
      SRC_MEM:  begin wen = 1'b1; wa = head_wa;   din = mem_d;       end
      default:  begin wen = 1'b0; end
    endcase
  end

  // Load data that lost the port parks in the skid; mem_ready guarantees it is empty.
  always_comb begin
    skid_full_d = skid_full_q;
    skid_wa_d   = skid_wa_q;
    skid_data_d = skid_data_q;
    if (src == SRC_SKID) skid_full_d = 1'b0;
    if (mem_acc && src != SRC_MEM) begin
      skid_full_d = 1'b1;
      skid_wa_d   = head_wa;
      skid_data_d = mem_d;
    end
    err_d = err_q
          | (ld_issue && fifo_full && !fifo_pop)
          | (mem_valid && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      skid_full_q <= 1'b0;
      skid_wa_q   <= '0;
      skid_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_wa_q   <= skid_wa_d;
      skid_data_q <= skid_data_d;
      err_q       <= err_d;
    end
  end

endmodule
